// File: rtl/bcd_conv_param.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with configurable width and digit count,
// optional two's-complement input, optional leading-zero skip, valid/ready on both sides.

module bcd_conv_param_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bcd_conv_param #(
  parameter  int BIN_W     = 32,
  parameter  int DIGITS    = 10,
  parameter  int SIGNED_EN = 0,
  parameter  int SKIP_LZ   = 0,
  localparam int BCD_W     = 4 * DIGITS,
  localparam int ND_W      = $clog2(DIGITS + 1),
  localparam int CNT_W     = $clog2(BIN_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BIN_W-1:0]  bin_data_i,
  input  logic              bin_signed_i,
  input  logic              bin_data_valid_i,
  output logic              bin_redy_o,
  output logic [BCD_W-1:0]  bcd_data_o,
  output logic              bcd_sign_o,
  output logic [ND_W-1:0]   bcd_ndigits_o,
  output logic              bcd_ovf_o,
  output logic              bcd_data_valid_o,
  input  logic              bcd_redy_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, CONVERT, COMPLETE} state_t;

  state_t                 state_q, state_d;
  logic [DIGITS-1:0][3:0] acc_q, acc_add;
  logic [BCD_W:0]         acc_shl;
  logic [BIN_W-1:0]       mag_q, mag_in, mag_ld;
  logic [CNT_W-1:0]       cnt_q, cnt_ld, lz;
  logic [ND_W-1:0]        nd_q, nd_nxt;
  logic                   sign_q, ovf_q, neg, accept, shift, last;

  // Per-digit add-3 correction ahead of the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_conv_param_add3 u_add3 (.din(acc_q[g]), .dout(acc_add[g]));
  end

  // Top bit of acc_shl is what falls off the top digit.
  assign acc_shl = {acc_add, mag_q[BIN_W-1]};
  assign last    = (cnt_q == CNT_W'(1));

  assign neg    = (SIGNED_EN != 0) && bin_signed_i && bin_data_i[BIN_W-1];
  assign mag_in = neg ? -bin_data_i : bin_data_i;

  always_comb begin
    lz = CNT_W'(BIN_W);
    for (int i = 0; i < BIN_W; i++)
      if (mag_in[i]) lz = CNT_W'(BIN_W - 1 - i);
  end

  // A zero magnitude still takes one shift so COMPLETE is reached the normal way.
  assign mag_ld = (SKIP_LZ != 0) ? mag_in << lz : mag_in;
  assign cnt_ld = (SKIP_LZ == 0)          ? CNT_W'(BIN_W) :
                  (lz == CNT_W'(BIN_W))   ? CNT_W'(1)     : CNT_W'(BIN_W) - lz;

  always_comb begin
    nd_nxt = ND_W'(1);
    for (int i = 0; i < DIGITS; i++)
      if (acc_shl[4*i +: 4] != 4'd0) nd_nxt = ND_W'(i + 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    bin_redy_o       = 1'b0;
    bcd_data_valid_o = 1'b0;
    busy_o           = 1'b1;
    accept           = 1'b0;
    shift            = 1'b0;
    case (state_q)
      IDLE: begin
        busy_o     = 1'b0;
        bin_redy_o = !rst_i;
        if (bin_data_valid_i && !rst_i) begin
          accept  = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        shift = 1'b1;
        if (last) state_d = COMPLETE;
      end
      COMPLETE: begin
        bcd_data_valid_o = 1'b1;
        if (bcd_redy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      mag_q  <= '0;
      cnt_q  <= '0;
      sign_q <= 1'b0;
      ovf_q  <= 1'b0;
      nd_q   <= '0;
    end else if (accept) begin
      acc_q  <= '0;
      mag_q  <= mag_ld;
      cnt_q  <= cnt_ld;
      sign_q <= neg;
      ovf_q  <= 1'b0;
    end else if (shift) begin
      acc_q <= acc_shl[BCD_W-1:0];
      mag_q <= mag_q << 1;
      cnt_q <= cnt_q - CNT_W'(1);
      ovf_q <= ovf_q | acc_shl[BCD_W];
      if (last) nd_q <= nd_nxt;
    end
  end

  assign bcd_data_o    = acc_q;
  assign bcd_sign_o    = sign_q;
  assign bcd_ovf_o     = ovf_q;
  assign bcd_ndigits_o = nd_q;

endmodule

// File: tb/tb_bcd_conv_param.sv
// Bench for bcd_conv_param: three configurations checked against an arithmetic reference model.
module tb_bcd_conv_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] bdat [3];
  logic [2:0]  bsgn, bvld, ordy_dir, rnd_bits;
  logic [2:0]  brdy, osgn, oovf, ovld, obusy, ordy;
  logic        rnd_rdy;
  logic [39:0] bcd0, bcd1;
  logic [11:0] bcd2;
  logic [3:0]  nd0, nd1;
  logic [1:0]  nd2;
  logic [79:0] obcd [3];
  int          ond [3];

  assign ordy = rnd_rdy ? rnd_bits : ordy_dir;

  always_comb begin
    obcd[0] = 80'(bcd0);
    obcd[1] = 80'(bcd1);
    obcd[2] = 80'(bcd2);
    ond[0]  = int'(nd0);
    ond[1]  = int'(nd1);
    ond[2]  = int'(nd2);
  end

  bcd_conv_param #(.BIN_W(32), .DIGITS(10), .SIGNED_EN(1), .SKIP_LZ(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .bin_data_i(bdat[0][31:0]), .bin_signed_i(bsgn[0]),
    .bin_data_valid_i(bvld[0]), .bin_redy_o(brdy[0]), .bcd_data_o(bcd0), .bcd_sign_o(osgn[0]),
    .bcd_ndigits_o(nd0), .bcd_ovf_o(oovf[0]), .bcd_data_valid_o(ovld[0]), .bcd_redy_i(ordy[0]),
    .busy_o(obusy[0]));

  bcd_conv_param #(.BIN_W(32), .DIGITS(10), .SIGNED_EN(0), .SKIP_LZ(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bin_data_i(bdat[1][31:0]), .bin_signed_i(bsgn[1]),
    .bin_data_valid_i(bvld[1]), .bin_redy_o(brdy[1]), .bcd_data_o(bcd1), .bcd_sign_o(osgn[1]),
    .bcd_ndigits_o(nd1), .bcd_ovf_o(oovf[1]), .bcd_data_valid_o(ovld[1]), .bcd_redy_i(ordy[1]),
    .busy_o(obusy[1]));

  bcd_conv_param #(.BIN_W(12), .DIGITS(3), .SIGNED_EN(1), .SKIP_LZ(1)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .bin_data_i(bdat[2][11:0]), .bin_signed_i(bsgn[2]),
    .bin_data_valid_i(bvld[2]), .bin_redy_o(brdy[2]), .bcd_data_o(bcd2), .bcd_sign_o(osgn[2]),
    .bcd_ndigits_o(nd2), .bcd_ovf_o(oovf[2]), .bcd_data_valid_o(ovld[2]), .bcd_redy_i(ordy[2]),
    .busy_o(obusy[2]));

  typedef struct {
    int          d;
    logic [79:0] bcd;
    logic        sgn;
    int          nd;
    logic        ovf;
    int          n;
  } exp_t;

  exp_t expq [$];
  int   ncmp = 0, nerr = 0, cyc = 0, lat_start = 0, lat_end = 0;
  logic rst_seen = 1'b1;
  int   acc_cyc [3];
  bit   seen [3];

  function automatic int bw(int d); return (d == 2) ? 12 : 32; endfunction
  function automatic int dg(int d); return (d == 2) ? 3 : 10;  endfunction

  // Reference: plain integer arithmetic on the magnitude, decimal digits by division.
  function automatic exp_t model(int d, logic [63:0] v, logic s);
    exp_t        e;
    logic [63:0] mask, mag, p10, r;
    logic [79:0] b;
    mask  = (64'd1 << bw(d)) - 64'd1;
    mag   = v & mask;
    e.d   = d;
    e.sgn = 1'b0;
    if (d != 1 && s && mag[bw(d)-1]) begin
      mag   = (mask + 64'd1 - mag) & mask;
      e.sgn = 1'b1;
    end
    p10 = 64'd1;
    for (int i = 0; i < dg(d); i++) p10 = p10 * 64'd10;
    e.ovf = (mag >= p10);
    r     = mag % p10;
    b     = '0;
    e.nd  = 1;
    for (int i = 0; i < dg(d); i++) begin
      b[4*i +: 4] = 4'(r % 64'd10);
      if (b[4*i +: 4] != 4'd0) e.nd = i + 1;
      r = r / 64'd10;
    end
    e.bcd = b;
    if (d == 0) e.n = bw(d);
    else begin
      e.n = 0;
      r   = mag;
      while (r != 64'd0) begin e.n++; r = r >> 1; end
      if (e.n == 0) e.n = 1;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // Single compare process: reset values, acceptance tracking and result checks for all DUTs.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst_seen) begin
        chk("rst_bcd", obcd[d], 80'd0);
        chk("rst_flags", 80'({osgn[d], oovf[d], ovld[d], obusy[d]}), 80'd0);
        chk("rst_ndigits", 80'(ond[d]), 80'd0);
        chk("rst_redy", 80'(brdy[d]), 80'(!rst));
      end
      if (rst) begin
        if (d == 0) expq.delete();
      end else begin
        if (bvld[d] && brdy[d]) begin
          expq.push_back(model(d, bdat[d], bsgn[d]));
          acc_cyc[d] = cyc;
          seen[d]    = 1'b0;
        end
        if (ovld[d]) begin
          if (expq.size() == 0 || expq[0].d != d) begin
            chk("spurious_valid", 80'(ovld[d]), 80'd0);
          end else begin
            chk("bcd", obcd[d], expq[0].bcd);
            chk("sign", 80'(osgn[d]), 80'(expq[0].sgn));
            chk("ndigits", 80'(ond[d]), 80'(expq[0].nd));
            chk("ovf", 80'(oovf[d]), 80'(expq[0].ovf));
            chk("redy_busy", 80'({brdy[d], obusy[d]}), 80'(2'b01));
            if (!seen[d]) chk("latency", 80'(cyc - acc_cyc[d] - 1), 80'(expq[0].n));
            seen[d] = 1'b1;
            if (ordy[d]) void'(expq.pop_front());
          end
        end
      end
    end
  end

  task automatic send(input int d, input logic [63:0] v, input logic s);
    int t = 0;
    bdat[d] = v;
    bsgn[d] = s;
    bvld[d] = 1'b1;
    while (!brdy[d] && t < 300) begin @(negedge clk); t++; end
    if (!brdy[d]) chk("send_timeout", 80'(brdy[d]), 80'd1);
    @(posedge clk); #1;
    bvld[d]   = 1'b0;
    lat_start = cyc;
  endtask

  task automatic get(input int d, output logic [79:0] b, output logic sg, output int nd,
                     output logic ov);
    int t = 0;
    @(negedge clk);
    while (!ovld[d] && t < 300) begin @(negedge clk); t++; end
    chk("result_timeout", 80'(ovld[d]), 80'd1);
    lat_end = cyc;
    b  = obcd[d];
    sg = osgn[d];
    nd = ond[d];
    ov = oovf[d];
    @(posedge clk); #1;
  endtask

  task automatic conv(input int d, input logic [63:0] v, input logic s, input logic [79:0] eb,
                      input logic es, input int en, input logic eo, input string nm);
    logic [79:0] b;
    logic        sg, ov;
    int          nd;
    send(d, v, s);
    get(d, b, sg, nd, ov);
    chk({nm, "_bcd"}, b, eb);
    chk({nm, "_sign"}, 80'(sg), 80'(es));
    chk({nm, "_ndigits"}, 80'(nd), 80'(en));
    chk({nm, "_ovf"}, 80'(ov), 80'(eo));
  endtask

  task automatic drain();
    int t = 0;
    while (expq.size() != 0 && t < 1000) begin @(negedge clk); t++; end
    @(posedge clk); #1;
  endtask

  initial begin
    rnd_bits = 3'b000;
    forever begin
      @(posedge clk); #1;
      rnd_bits = 3'($urandom);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [79:0] hb;
    int          t, seenv;
    for (int d = 0; d < 3; d++) bdat[d] = 64'd0;
    bsgn     = 3'b000;
    bvld     = 3'b000;
    ordy_dir = 3'b111;
    rnd_rdy  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Defaults-style unsigned and signed conversions
    conv(0, 64'hFFFF_FFFF, 1'b0, 80'h4294967295, 1'b0, 10, 1'b0, "umax");
    chk("umax_latency", 80'(lat_end - lat_start), 80'd32);
    conv(0, 64'h8000_0000, 1'b1, 80'h2147483648, 1'b1, 10, 1'b0, "smin");
    conv(0, 64'hFFFF_FFFF, 1'b1, 80'h1, 1'b1, 1, 1'b0, "sneg1");
    conv(0, 64'hFFFF_FFFF, 1'b0, 80'h4294967295, 1'b0, 10, 1'b0, "sflag0");

    // Leading-zero skip
    conv(1, 64'd0, 1'b0, 80'h0, 1'b0, 1, 1'b0, "zero");
    chk("zero_latency", 80'(lat_end - lat_start), 80'd1);
    conv(1, 64'd9, 1'b0, 80'h9, 1'b0, 1, 1'b0, "nine");
    chk("nine_latency", 80'(lat_end - lat_start), 80'd4);
    conv(1, 64'd1000, 1'b0, 80'h1000, 1'b0, 4, 1'b0, "k1");
    chk("k1_latency", 80'(lat_end - lat_start), 80'd10);
    conv(1, 64'hFFFF_FFFF, 1'b1, 80'h4294967295, 1'b0, 10, 1'b0, "signoff");

    // Overflow with three digits
    conv(2, 64'd999, 1'b0, 80'h999, 1'b0, 3, 1'b0, "d999");
    conv(2, 64'd1000, 1'b0, 80'h000, 1'b0, 1, 1'b1, "d1000");
    conv(2, 64'd4095, 1'b0, 80'h095, 1'b0, 2, 1'b1, "d4095");
    conv(2, 64'h800, 1'b1, 80'h048, 1'b1, 2, 1'b1, "dneg");
    conv(2, 64'd0, 1'b1, 80'h000, 1'b0, 1, 1'b0, "dzero_s");

    // Backpressure: hold the result, ignore a new input pulse, then release
    ordy_dir[0] = 1'b0;
    send(0, 64'd777, 1'b0);
    t = 0;
    @(negedge clk);
    while (!ovld[0] && t < 100) begin @(negedge clk); t++; end
    hb = obcd[0];
    chk("bp_result", hb, 80'h777);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin bdat[0] = 64'd31; bvld[0] = 1'b1; end
      if (k == 6) bvld[0] = 1'b0;
      @(negedge clk);
      chk("bp_stable", obcd[0], hb);
      chk("bp_valid_redy", 80'({ovld[0], brdy[0]}), 80'(2'b10));
    end
    @(posedge clk); #1;
    ordy_dir[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 80'(ovld[0]), 80'd1);
    @(negedge clk);
    chk("bp_after_handshake", 80'({ovld[0], brdy[0]}), 80'(2'b01));
    @(posedge clk); #1;

    conv(0, 64'd123, 1'b0, 80'h123, 1'b0, 3, 1'b0, "b2b_a");
    conv(0, 64'd456, 1'b0, 80'h456, 1'b0, 3, 1'b0, "b2b_b");

    // Reset in the middle of a conversion
    send(0, 64'd12345, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_bcd", obcd[0], 80'd0);
    chk("abort_state", 80'({ovld[0], obusy[0], brdy[0]}), 80'(3'b001));
    seenv = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ovld[0]) seenv++;
    end
    chk("abort_no_valid", 80'(seenv), 80'd0);
    @(posedge clk); #1;
    conv(0, 64'd42, 1'b0, 80'h42, 1'b0, 2, 1'b0, "after_rst");
    chk("after_rst_latency", 80'(lat_end - lat_start), 80'd32);

    // Random traffic with random consumer stalls
    rnd_rdy = 1'b1;
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 40; k++) begin
        logic [63:0] v;
        v = {32'd0, $urandom};
        if ($urandom_range(0, 3) == 0) v = 64'($urandom_range(0, 1100));
        send(d, v, 1'($urandom_range(0, 1)));
      end
      drain();
    end
    rnd_rdy = 1'b0;
    drain();
    chk("queue_drained", 80'(expq.size()), 80'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
